// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and constants for the counter sweep sequencer
package sweep_pkg;

  localparam int WIDTH  = 8;
  localparam int PASS_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_counter_core.sv
// rtl/sweep_counter_core.sv - loadable up/down counter stepped by the sweep controller
module sweep_counter_core #(
  parameter int WIDTH = sweep_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);
  import sweep_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= data;
    end else if (en) begin
      count <= (up_down == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - sweep command sequencer: captures endpoints, bounces the counter, reports done/abort
module counter_sweep_ctrl #(
  parameter int WIDTH  = sweep_pkg::WIDTH,
  parameter int PASS_W = sweep_pkg::PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic [PASS_W-1:0] passes,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  import sweep_pkg::*;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  start_q, end_q, target;
  logic [PASS_W-1:0] pass_cnt;
  logic              dir_q, aborted_q;
  logic              at_target;
  logic              capture, core_load, core_en, core_up, turnaround, abort_hit;

  assign at_target = (count == target);
  assign core_up   = (target > count) ? DIR_UP : DIR_DOWN;

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    core_load  = 1'b0;
    core_en    = 1'b0;
    turnaround = 1'b0;
    abort_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else begin
          core_load = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // abort wins over stepping so the count freezes where it was cancelled
        if (abort) begin
          abort_hit = 1'b1;
          state_nxt = IDLE;
        end else if (!pause) begin
          if (!at_target) begin
            core_en = 1'b1;
          end else if (pass_cnt != '0) begin
            turnaround = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= '0;
      end_q     <= '0;
      target    <= '0;
      pass_cnt  <= '0;
      dir_q     <= DIR_UP;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
      if (capture) begin
        start_q  <= start_val;
        end_q    <= end_val;
        target   <= end_val;
        pass_cnt <= passes;
      end
      if (core_load) begin
        dir_q <= (end_q > start_q) ? DIR_UP : DIR_DOWN;
      end
      if (core_en) begin
        dir_q <= core_up;
      end
      if (turnaround) begin
        target   <= (target == end_q) ? start_q : end_q;
        pass_cnt <= pass_cnt - 1'b1;
        dir_q    <= ~dir_q;
      end
    end
  end

  sweep_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .en     (core_en),
    .up_down(core_up),
    .data   (start_q),
    .count  (count)
  );

  assign dir     = dir_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - directed self-checking bench for counter_sweep_ctrl
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, abort;
  logic [7:0] start_val, end_val;
  logic [3:0] passes;
  logic [7:0] count;
  logic       dir, busy, done, aborted;
  int         total = 0;
  int         bad = 0;

  counter_sweep_ctrl #(.WIDTH(8), .PASS_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .start_val(start_val),
    .end_val  (end_val),
    .passes   (passes),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] e, input logic [3:0] p);
    start     = 1'b1;
    start_val = s;
    end_val   = e;
    passes    = p;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    start_val = '0; end_val = '0; passes = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", dir); end
    total++; if ({busy, done, aborted} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, aborted}); end
    next_cycle();
  endtask

  task automatic test_single_sweep();
    logic [7:0] want;
    issue(8'd10, 8'd15, 4'd0);
    next_cycle();
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL single_load busy=%b done=%b want busy=1 done=0", busy, done); end
    for (int c = 2; c <= 8; c++) begin
      next_cycle();
      want = (c <= 7) ? 8'(8 + c) : 8'd15;
      total++; if (count !== want) begin bad++; $display("FAIL single_count cyc=%0d got=%0d want=%0d", c, count, want); end
      total++; if (dir !== 1'b1) begin bad++; $display("FAIL single_dir cyc=%0d got=%b want=1", c, dir); end
      total++; if (busy !== 1'b1 || done !== (c == 8)) begin bad++; $display("FAIL single_flags cyc=%0d busy=%b done=%b", c, busy, done); end
    end
    next_cycle();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_end busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_cnt [12] = '{8'd200, 8'd199, 8'd198, 8'd197, 8'd197, 8'd198,
                                 8'd199, 8'd200, 8'd200, 8'd199, 8'd198, 8'd197};
    logic       exp_dir [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    issue(8'd200, 8'd197, 4'd2);
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL bounce_count cyc=%0d got=%0d want=%0d", i + 2, count, exp_cnt[i]); end
      total++; if (dir !== exp_dir[i]) begin bad++; $display("FAIL bounce_dir cyc=%0d got=%b want=%b", i + 2, dir, exp_dir[i]); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL bounce_early_done cyc=%0d got=%b want=0", i + 2, done); end
    end
    next_cycle();
    total++; if (done !== 1'b1 || count !== 8'd197) begin bad++; $display("FAIL bounce_done cyc=14 done=%b count=%0d want 1 197", done, count); end
    next_cycle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bounce_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_equal_endpoints();
    issue(8'd42, 8'd42, 4'd0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    total++; if (count !== 8'd42 || done !== 1'b0) begin bad++; $display("FAIL equal0_c2 count=%0d done=%b want 42 0", count, done); end
    next_cycle();
    total++; if (count !== 8'd42 || done !== 1'b1) begin bad++; $display("FAIL equal0_done count=%0d done=%b want 42 1", count, done); end
    next_cycle();
    issue(8'd42, 8'd42, 4'd3);
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      next_cycle();
      total++; if (count !== 8'd42 || done !== 1'b0) begin bad++; $display("FAIL equal3_hold cyc=%0d count=%0d done=%b want 42 0", c, count, done); end
    end
    next_cycle();
    total++; if (count !== 8'd42 || done !== 1'b1) begin bad++; $display("FAIL equal3_done count=%0d done=%b want 42 1", count, done); end
    next_cycle();
  endtask

  task automatic test_pause_full_range();
    int         done_cyc = 0;
    bit         wrapped = 1'b0;
    logic [7:0] prev = 8'd0;
    issue(8'd0, 8'd255, 4'd0);
    next_cycle();
    start = 1'b0;
    for (int c = 2; c <= 280 && done_cyc == 0; c++) begin
      next_cycle();
      pause = (c >= 50 && c <= 54);
      if (c >= 50 && c <= 55) begin
        total++; if (count !== 8'd48) begin bad++; $display("FAIL pause_hold cyc=%0d got=%0d want=48", c, count); end
      end
      if (c == 56) begin
        total++; if (count !== 8'd49) begin bad++; $display("FAIL pause_resume got=%0d want=49", count); end
      end
      if (count < prev) wrapped = 1'b1;
      prev = count;
      if (done === 1'b1) done_cyc = c;
    end
    pause = 1'b0;
    total++; if (done_cyc != 263) begin bad++; $display("FAIL pause_done_cycle got=%0d want=263", done_cyc); end
    total++; if (wrapped || count !== 8'd255) begin bad++; $display("FAIL pause_no_wrap wrapped=%b count=%0d want 0 255", wrapped, count); end
    next_cycle();
  endtask

  task automatic test_abort();
    issue(8'd50, 8'd60, 4'd0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    issue(8'd0, 8'd5, 4'd1);
    next_cycle();
    start = 1'b0;
    next_cycle();
    total++; if (count !== 8'd53) begin bad++; $display("FAIL abort_pre count=%0d want=53", count); end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    total++; if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_pulse aborted=%b busy=%b done=%b want 1 0 0", aborted, busy, done); end
    total++; if (count !== 8'd53) begin bad++; $display("FAIL abort_count got=%0d want=53", count); end
    issue(8'd7, 8'd8, 4'd0);
    next_cycle();
    start = 1'b0;
    total++; if (aborted !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL abort_restart aborted=%b busy=%b want 0 1", aborted, busy); end
    next_cycle();
    total++; if (count !== 8'd7) begin bad++; $display("FAIL abort_new_load got=%0d want=7", count); end
    next_cycle();
    total++; if (count !== 8'd8 || done !== 1'b0) begin bad++; $display("FAIL abort_new_step count=%0d done=%b want 8 0", count, done); end
    next_cycle();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_new_done got=%b want=1", done); end
    next_cycle();
  endtask

  task automatic test_start_with_abort_idle();
    issue(8'd5, 8'd5, 4'd0);
    abort = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    total++; if (busy !== 1'b1 || aborted !== 1'b0) begin bad++; $display("FAIL idle_abort_start busy=%b aborted=%b want 1 0", busy, aborted); end
    next_cycle();
    next_cycle();
    total++; if (done !== 1'b1 || aborted !== 1'b0) begin bad++; $display("FAIL idle_abort_done done=%b aborted=%b want 1 0", done, aborted); end
    next_cycle();
  endtask

  task automatic test_reset_mid_run();
    issue(8'd100, 8'd110, 4'd0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    total++; if (count !== 8'd102) begin bad++; $display("FAIL rst_mid_pre count=%0d want=102", count); end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    total++; if (count !== 8'd0 || busy !== 1'b0 || dir !== 1'b1) begin bad++; $display("FAIL rst_mid_state count=%0d busy=%b dir=%b want 0 0 1", count, busy, dir); end
    total++; if (done !== 1'b0 || aborted !== 1'b0) begin bad++; $display("FAIL rst_mid_pulse done=%b aborted=%b want 0 0", done, aborted); end
    next_cycle();
    total++; if ({busy, done, aborted} !== 3'b000) begin bad++; $display("FAIL rst_mid_after flags=%b want=000", {busy, done, aborted}); end
    issue(8'd20, 8'd30, 4'd0);
    reset = 1'b1;
    next_cycle();
    start = 1'b0;
    reset = 1'b0;
    total++; if (busy !== 1'b0 || count !== 8'd0) begin bad++; $display("FAIL rst_start_drop busy=%b count=%0d want 0 0", busy, count); end
    next_cycle();
    total++; if (busy !== 1'b0 || count !== 8'd0) begin bad++; $display("FAIL rst_start_idle busy=%b count=%0d want 0 0", busy, count); end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_bounce();
    test_equal_endpoints();
    test_pause_full_range();
    test_abort();
    test_start_with_abort_idle();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the 8-bit up/down counter datapath: accepts a sweep command (start value, end value, bounce passes), loads the counter, steps it toward each endpoint, and reports completion with a done/busy handshake. It owns the counter's load, enable and direction controls, so upstream logic issues one command per sweep instead of driving the counter every cycle.

## Interface
- WIDTH, 8, counter and endpoint width
- PASS_W, 4, width of the bounce pass count

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; forces IDLE and clears all state
- start  input  1  command strobe; accepted only in IDLE
- start_val  input  WIDTH  first endpoint, captured on accepted start
- end_val  input  WIDTH  second endpoint, captured on accepted start
- passes  input  PASS_W  extra traversals after the first sweep (0 = single sweep), captured on start
- pause  input  1  freezes RUN while high
- abort  input  1  cancels the active command
- count  output  WIDTH  counter value
- dir  output  1  current direction, 1 = up
- busy  output  1  high in LOAD, RUN and DONE
- done  output  1  one-cycle pulse on normal completion
- aborted  output  1  one-cycle pulse on abort

## Operation
- States: IDLE, LOAD, RUN, DONE.
- Reset values: state IDLE, count 0, dir 1, busy 0, done 0, aborted 0, internal target 0, pass counter 0.
- IDLE: start=1 captures start_val, end_val and passes. target <= end_val. Next state is LOAD. abort is ignored in IDLE, so start and abort together are a normal start.
- LOAD: loads start_val into the counter. Next state is RUN.
- RUN, with pause=0:
  - count != target: count steps by 1 toward target. dir = (target > count).
  - count == target and pass counter > 0: no step. target swaps to the other captured endpoint. pass counter decrements. dir flips. State stays RUN.
  - count == target and pass counter == 0: next state is DONE.
- RUN, with pause=1: count, target and pass counter all hold. The completion and turnaround checks are also frozen.
- DONE: done=1 for exactly one cycle, then IDLE. count holds the final endpoint.
- abort=1 in LOAD or RUN: next state is IDLE, aborted pulses for one cycle, count holds its current value, and done is not asserted. abort in DONE is ignored.
- start while busy is ignored. The command registers do not change.
- Arithmetic: steps are always toward target, within [min(S,E), max(S,E)]. The counter never wraps. S=0, E=255 is legal.
- start_val == end_val: RUN sees equality on its first cycle. Each pass costs one turnaround cycle.
- reset mid-operation returns to the reset values on the next edge. No done or aborted pulse is produced.

## Timing
- start is sampled high at the edge ending cycle 0.
- LOAD is cycle 1. count = S from cycle 2.
- N = |E−S|. Single sweep: count = E in cycle N+2, done=1 in cycle N+3, busy falls in cycle N+4.
- Each bounce pass adds N+1 cycles: one turnaround hold plus N steps.
- Each paused RUN cycle adds one cycle.
- abort sampled in cycle k: IDLE and aborted=1 in cycle k+1.
- A new start is accepted in the first IDLE cycle after done or aborted.

## Structure
- Package sweep_pkg:
  - state enum (IDLE, LOAD, RUN, DONE)
  - WIDTH and PASS_W default constants
  - dir encoding constants DIR_UP and DIR_DOWN
- Sub-module sweep_counter_core:
  - ports: clk, reset, load, en, up_down, data → count
  - synchronous reset; load has priority over en
- The controller FSM, the captured endpoints and the pass counter live in counter_sweep_ctrl.

## Test plan
- Reset, then start with S=10, E=15, passes=0 → count 10,11,…,15 in cycles 2–7; done pulse in cycle 8; busy 1 in cycles 1–8.
- S=200, E=197, passes=2 → count 200→197, hold, 197→200, hold, 200→197; dir follows each leg; done in cycle 14.
- S=E=42, passes=0 → done in cycle 3. With passes=3 → done in cycle 6, count constant at 42.
- S=0, E=255 with pause high for 5 cycles mid-sweep → no wrap, count frozen during pause, done in cycle 263.
- S=50, E=60: abort in cycle 5 → aborted in cycle 6, count=53, no done. A start in cycle 6 is accepted; a start issued mid-run is ignored.
- Synchronous reset asserted mid-RUN → next cycle count 0, busy 0, no done or aborted pulse. Reset in the same cycle as start → command dropped.
